// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// reset PC default and the NOP word.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle: redirect/stall from the core, imem request/response,
// and the instruction handed to decode.
interface pc_fetch_sequencer_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               stall;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [ADDR_W-1:0]  pc_plus4;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4
  );

endinterface

// File: rtl/pc_fetch_sequencer_adder.sv
// PC incrementer: next sequential word address, wrapping modulo 2^W.
module pc_fetch_sequencer_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] pc_i,
  output logic [W-1:0] pc_plus4_o
);

  localparam logic [W-1:0] PC_STEP = {{(W-3){1'b0}}, 3'b100};

  assign pc_plus4_o = pc_i + PC_STEP;

endmodule

// File: rtl/pc_fetch_sequencer_chk.sv
// Protocol checks for the fetch sequencer: responses only while one is owed,
// and the PC stays word aligned.
module pc_fetch_sequencer_chk
  import pc_fetch_sequencer_pkg::*;
(
  input logic         clk,
  input logic         reset,
  input logic         imem_rvalid_i,
  input fetch_state_e state_i,
  input logic [1:0]   pc_lsb_i
);

  a_rvalid_owed: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid_i |-> (state_i == ST_WAIT || state_i == ST_FLUSH));

  a_pc_aligned: assert property (@(posedge clk) disable iff (reset)
    pc_lsb_i == 2'b00);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Holds the architectural PC, issues one-outstanding imem reads and hands each
// fetched word to decode with its PC and PC+4; redirects cancel in-flight work.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input logic                    clk,
  input logic                    reset,
  pc_fetch_sequencer_if.master   bus
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic               iv_q, iv_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [ADDR_W-1:0]  p4_q, p4_d;
  logic [ADDR_W-1:0]  pc_plus4_s;
  logic [ADDR_W-1:0]  redir_pc_s;
  logic               gnt_s;

  pc_fetch_sequencer_adder #(.W(ADDR_W)) u_adder (
    .pc_i       (pc_q),
    .pc_plus4_o (pc_plus4_s)
  );

  // A grant only counts against a request actually on the bus
  assign gnt_s      = bus.imem_gnt & req_q;
  assign redir_pc_s = bus.redirect_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      iv_q    <= 1'b0;
      instr_q <= INSTR_W'(INSTR_NOP);
      ipc_q   <= {ADDR_W{1'b0}};
      p4_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      iv_q    <= iv_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      p4_q    <= p4_d;
    end
  end

  // Next-state, PC update and registered-output next values
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = 1'b0;
    iv_d    = iv_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    p4_d    = p4_q;
    case (state_q)
      ST_REQ: begin
        iv_d = 1'b0;
        if (bus.redirect_valid) begin
          pc_d = redir_pc_s;
          if (gnt_s) begin
            state_d = ST_FLUSH;
          end else begin
            req_d = 1'b1;
          end
        end else if (gnt_s) begin
          state_d = ST_WAIT;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          if (bus.redirect_valid) begin
            pc_d    = redir_pc_s;
            state_d = ST_REQ;
            req_d   = 1'b1;
          end else begin
            iv_d    = 1'b1;
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            p4_d    = pc_plus4_s;
            if (bus.stall) begin
              state_d = ST_HOLD;
            end else begin
              pc_d    = pc_plus4_s;
              state_d = ST_REQ;
              req_d   = 1'b1;
            end
          end
        end else if (bus.redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid || !bus.stall) begin
          iv_d    = 1'b0;
          pc_d    = bus.redirect_valid ? redir_pc_s : pc_plus4_s;
          state_d = ST_REQ;
          req_d   = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_FLUSH: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc_s;
        end else begin
          pc_d = pc_q;
        end
        // The orphan response is swallowed here and never reaches decode
        if (bus.imem_rvalid) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_REQ;
        iv_d    = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = iv_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.pc_plus4    = p4_q;

  pc_fetch_sequencer_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .imem_rvalid_i (bus.imem_rvalid),
    .state_i       (state_q),
    .pc_lsb_i      (pc_q[1:0])
  );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed fetch scenarios plus randomized
// traffic against a transaction-level model of the fetch rules.
module tb_pc_fetch_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  pc_fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model: outstanding read, response to be dropped, word held for decode
  bit          m_out, m_drop, m_hold, m_req, m_iv;
  logic [31:0] m_pc, m_instr, m_ipc, m_p4;

  // memory model
  bit          pend;
  int          dly, dly_min, dly_max;
  logic [31:0] words[$];

  // observation logs
  logic [31:0] addr_log[$];
  logic [31:0] iv_instr[$];
  logic [31:0] iv_pc[$];
  logic [31:0] iv_p4[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic clear_logs();
    addr_log.delete();
    iv_instr.delete();
    iv_pc.delete();
    iv_p4.delete();
  endtask

  task automatic model_reset();
    m_out = 1'b0; m_drop = 1'b0; m_hold = 1'b0; m_req = 1'b0; m_iv = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_p4 = 32'h0;
  endtask

  task automatic model_step(input bit redir, input logic [31:0] rpc, input bit stl,
                            input bit g, input bit rv, input logic [31:0] rd);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (m_hold) begin
      if (redir || !stl) begin
        m_iv = 1'b0; m_hold = 1'b0; m_req = 1'b1;
        m_pc = redir ? tgt : m_pc + 32'd4;
      end
    end else if (m_out && m_drop) begin
      if (redir) m_pc = tgt;
      if (rv) begin m_out = 1'b0; m_drop = 1'b0; m_req = 1'b1; end
    end else if (m_out) begin
      if (rv) begin
        m_out = 1'b0;
        if (redir) begin
          m_pc = tgt; m_req = 1'b1;
        end else begin
          m_iv = 1'b1; m_instr = rd; m_ipc = m_pc; m_p4 = m_pc + 32'd4;
          if (stl) m_hold = 1'b1;
          else begin m_pc = m_pc + 32'd4; m_req = 1'b1; end
        end
      end else if (redir) begin
        m_pc = tgt; m_drop = 1'b1;
      end
    end else begin
      m_iv = 1'b0;
      if (redir) m_pc = tgt;
      if (m_req && g) begin m_out = 1'b1; m_drop = redir; m_req = 1'b0; end
      else m_req = 1'b1;
    end
  endtask

  task automatic drive_idle();
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.stall = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
  endtask

  // Asserts reset mid-cycle, checks the cleared outputs, then releases it
  task automatic do_reset(input int n, input bit rv_in_reset);
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    if (rv_in_reset) begin bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0BAD; end
    pend = 1'b0; words.delete();
    model_reset();
    #1;
    check_val("rst_req", bus.imem_req, 32'h0);
    check_val("rst_addr", bus.imem_addr, 32'h0);
    check_val("rst_iv", bus.instr_valid, 32'h0);
    check_val("rst_instr", bus.instr, 32'h0);
    check_val("rst_ipc", bus.instr_pc, 32'h0);
    check_val("rst_p4", bus.pc_plus4, 32'h0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(posedge clk);
    model_step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // One clock: compare outputs, run the memory, drive inputs, step the model
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit stl, input bit allow_gnt);
    bit rv, g;
    logic [31:0] rd;
    @(negedge clk);
    check_val("imem_req", bus.imem_req, m_req);
    if (m_req) check_val("imem_addr", bus.imem_addr, m_pc);
    check_val("instr_valid", bus.instr_valid, m_iv);
    check_val("instr", bus.instr, m_instr);
    check_val("instr_pc", bus.instr_pc, m_ipc);
    check_val("pc_plus4", bus.pc_plus4, m_p4);
    if (bus.instr_valid) begin
      iv_instr.push_back(bus.instr); iv_pc.push_back(bus.instr_pc); iv_p4.push_back(bus.pc_plus4);
    end
    rv = 1'b0; rd = 32'h0;
    if (pend) begin
      if (dly == 0) begin
        rv = 1'b1; pend = 1'b0;
        rd = (words.size() > 0) ? words.pop_front() : $urandom();
      end else dly--;
    end
    g = allow_gnt && bus.imem_req && !pend && !rv;
    if (g) begin
      pend = 1'b1;
      dly = $urandom_range(dly_max, dly_min);
      addr_log.push_back(bus.imem_addr);
    end
    bus.redirect_valid = redir; bus.redirect_pc = rpc; bus.stall = stl;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd;
    @(posedge clk);
    model_step(redir, rpc, stl, g, rv, rd);
  endtask

  initial begin
    int n22;
    drive_idle();
    dly_min = 0; dly_max = 0;

    // sequential fetch, gnt same cycle, rvalid one cycle later
    do_reset(3, 1'b0);
    words = '{32'h11, 32'h22, 32'h33};
    clear_logs();
    repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("t1_addr0", q_at(addr_log, 0), 32'h0);
    check_val("t1_addr1", q_at(addr_log, 1), 32'h4);
    check_val("t1_addr2", q_at(addr_log, 2), 32'h8);
    for (int i = 0; i < 3; i++) begin
      check_val("t1_instr", q_at(iv_instr, i), 32'h11 * (i + 1));
      check_val("t1_ipc", q_at(iv_pc, i), 32'(4 * i));
      check_val("t1_p4", q_at(iv_p4, i), 32'(4 * i + 4));
    end

    // grant withheld with PC at 0x8
    do_reset(2, 1'b0);
    clear_logs();
    for (int i = 0; i < 20 && addr_log.size() < 2; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("t2_grants", addr_log.size(), 32'd2);
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t2_req", bus.imem_req, 32'h1);
      check_val("t2_addr", bus.imem_addr, 32'h8);
      check_val("t2_iv", bus.instr_valid, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end

    // redirect while waiting: orphan 0xDEAD dropped, refetch from 0x40
    dly_min = 2; dly_max = 2;
    words = '{32'h0000_DEAD, 32'h5A5A_0040};
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    clear_logs();
    dly_min = 0; dly_max = 0;
    cycle(1'b1, 32'h40, 1'b0, 1'b1);
    for (int i = 0; i < 20 && iv_instr.size() == 0; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("t3_addr", q_at(addr_log, 0), 32'h40);
    check_val("t3_instr", q_at(iv_instr, 0), 32'h5A5A_0040);
    check_val("t3_ipc", q_at(iv_pc, 0), 32'h40);

    // stall on arrival of 0x22@0x4
    do_reset(2, 1'b0);
    words = '{32'h11, 32'h22, 32'h33};
    clear_logs();
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    n22 = 0;
    foreach (iv_instr[i]) if (iv_instr[i] == 32'h22) n22++;
    check_val("t4_hold_cycles", n22, 32'd5);
    check_val("t4_next_addr", q_at(addr_log, 2), 32'h8);

    // redirect to an unaligned top-of-memory target, then wrap
    do_reset(2, 1'b0);
    clear_logs();
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("t5_addr0", q_at(addr_log, 0), 32'hFFFF_FFFC);
    check_val("t5_addr1", q_at(addr_log, 1), 32'h0);
    check_val("t5_ipc", q_at(iv_pc, 0), 32'hFFFF_FFFC);
    check_val("t5_p4", q_at(iv_p4, 0), 32'h0);

    // reset between gnt and rvalid, with rvalid during reset
    do_reset(2, 1'b0);
    dly_min = 1; dly_max = 1;
    clear_logs();
    for (int i = 0; i < 10 && addr_log.size() == 0; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("t6_granted", addr_log.size(), 32'd1);
    do_reset(1, 1'b1);
    clear_logs();
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("t6_no_iv", iv_instr.size(), 32'd0);

    // randomized traffic
    dly_min = 0; dly_max = 3;
    do_reset(2, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFE : $urandom();
      cycle($urandom_range(15, 0) == 0, rpc, $urandom_range(2, 0) == 0,
            $urandom_range(3, 0) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
